// File: rtl/arb_pkg.sv
// Shared types and AXI constants for the cache-to-AXI read/write arbiter.
package arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = 4;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {OWNER_I = 1'b0, OWNER_D = 1'b1} owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } ar_req_t;

endpackage

// File: rtl/rd_grant_pick.sv
// Read-grant tie-break: fixed D-over-I priority, or alternating on ties
// when ARB_ROUND_ROBIN_EN is defined.
module rd_grant_pick
  import arb_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   grant_hs,
  input  owner_e grant_owner,
  output owner_e pick_c
);

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_grant;

  // Remember who won the most recent AR handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= OWNER_I;
    end else if (grant_hs) begin
      last_grant <= grant_owner;
    end
  end

  always_comb begin
    pick_c = OWNER_I;
    if (i_req && d_req) begin
      pick_c = (last_grant == OWNER_I) ? OWNER_D : OWNER_I;
    end else if (d_req) begin
      pick_c = OWNER_D;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, resetn, i_req, grant_hs, grant_owner};

  always_comb begin
    pick_c = OWNER_I;
    if (d_req) begin
      pick_c = OWNER_D;
    end
  end
`endif

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI master between I-cache (read) and D-cache (read/write).
// Optional: ARB_ROUND_ROBIN_EN selects alternating tie-break on reads.
module cache_axi_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned LINE_OFFSET_W = 5,
  parameter logic [3:0]  ID_I          = 4'd0,
  parameter logic [3:0]  ID_D          = 4'd1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [LEN_W-1:0]  i_arlen,
  input  logic              i_arvalid,
  output logic              i_arready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rlast,
  output logic              i_rvalid,
  input  logic              i_rready,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [LEN_W-1:0]  d_arlen,
  input  logic              d_arvalid,
  output logic              d_arready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rlast,
  output logic              d_rvalid,
  input  logic              d_rready,
  input  logic [ADDR_W-1:0] d_awaddr,
  input  logic [LEN_W-1:0]  d_awlen,
  input  logic [2:0]        d_awsize,
  input  logic              d_awvalid,
  output logic              d_awready,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  input  logic              d_wlast,
  input  logic              d_wvalid,
  output logic              d_wready,
  output logic              d_bvalid,
  input  logic              d_bready,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [LEN_W-1:0]  m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [ID_W-1:0]   m_awid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [LEN_W-1:0]  m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ID_W-1:0]   m_wid,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [ID_W-1:0]   m_bid,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);

  localparam int unsigned LINE_W = ADDR_W - LINE_OFFSET_W;

  rd_state_e         r_state, r_next;
  wr_state_e         w_state, w_next;
  owner_e            owner, pick_c;
  ar_req_t           ar_q, i_ar_c, d_ar_c;
  logic [LINE_W-1:0] wline;
  logic              d_hazard_c, d_elig_c, any_req_c, ar_hs_c, own_rready_c;
  logic              unused_resp;

  assign unused_resp = ^{m_rid, m_rresp, m_bid, m_bresp};

  // D read to the line currently being written back must wait for B.
  assign d_hazard_c   = (w_state != W_IDLE) &&
                        (d_araddr[ADDR_W-1:LINE_OFFSET_W] == wline);
  assign d_elig_c     = d_arvalid && !d_hazard_c;
  assign any_req_c    = i_arvalid || d_elig_c;
  assign ar_hs_c      = (r_state == R_ADDR) && m_arready;
  assign own_rready_c = (owner == OWNER_D) ? d_rready : i_rready;
  assign i_ar_c       = '{addr: i_araddr, len: i_arlen};
  assign d_ar_c       = '{addr: d_araddr, len: d_arlen};

  rd_grant_pick u_pick (
    .clk         (clk),
    .resetn      (resetn),
    .i_req       (i_arvalid),
    .d_req       (d_elig_c),
    .grant_hs    (ar_hs_c),
    .grant_owner (owner),
    .pick_c      (pick_c)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  // Ownership and AR fields are captured once and held until the handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner <= OWNER_I;
      ar_q  <= '0;
    end else if ((r_state == R_IDLE) && any_req_c) begin
      owner <= pick_c;
      ar_q  <= (pick_c == OWNER_D) ? d_ar_c : i_ar_c;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wline <= '0;
    end else if ((w_state == W_IDLE) && d_awvalid && m_awready) begin
      wline <= d_awaddr[ADDR_W-1:LINE_OFFSET_W];
    end
  end

  always_comb begin
    r_next    = r_state;
    m_arvalid = 1'b0;
    i_arready = 1'b0;
    d_arready = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rlast   = 1'b0;
    d_rlast   = 1'b0;
    m_rready  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (any_req_c) r_next = R_ADDR;
      end
      R_ADDR: begin
        m_arvalid = 1'b1;
        i_arready = m_arready && (owner == OWNER_I);
        d_arready = m_arready && (owner == OWNER_D);
        if (m_arready) r_next = R_DATA;
      end
      R_DATA: begin
        i_rvalid = m_rvalid && (owner == OWNER_I);
        d_rvalid = m_rvalid && (owner == OWNER_D);
        i_rlast  = m_rlast && (owner == OWNER_I);
        d_rlast  = m_rlast && (owner == OWNER_D);
        m_rready = own_rready_c;
        if (m_rvalid && own_rready_c && m_rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next    = w_state;
    m_awvalid = 1'b0;
    d_awready = 1'b0;
    m_wvalid  = 1'b0;
    d_wready  = 1'b0;
    d_bvalid  = 1'b0;
    m_bready  = 1'b0;
    case (w_state)
      W_IDLE: begin
        m_awvalid = d_awvalid;
        d_awready = m_awready;
        if (d_awvalid && m_awready) w_next = W_DATA;
      end
      W_DATA: begin
        m_wvalid = d_wvalid;
        d_wready = m_wready;
        if (d_wvalid && m_wready && d_wlast) w_next = W_RESP;
      end
      W_RESP: begin
        d_bvalid = m_bvalid;
        m_bready = d_bready;
        if (m_bvalid && d_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign m_arid    = (owner == OWNER_D) ? ID_D : ID_I;
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arsize  = SIZE_WORD;
  assign m_arburst = BURST_INCR;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

  assign m_awid    = ID_D;
  assign m_awaddr  = d_awaddr;
  assign m_awlen   = d_awlen;
  assign m_awsize  = d_awsize;
  assign m_awburst = BURST_INCR;
  assign m_wid     = ID_D;
  assign m_wdata   = d_wdata;
  assign m_wstrb   = d_wstrb;
  assign m_wlast   = d_wlast;

endmodule
